// File: rtl/cfg_chain_rx.sv
// Config-chain receiver sitting behind the JTAG TAP CONFIG data register.
// Hunts for a sync word in the serial Shift-DR stream. Once synced, it turns
// every DR scan of exactly DATA_W bits into one coefficient write, and flags
// every scan of any other length as an error.
module cfg_chain_rx #(
    parameter int                DATA_W    = 8,
    parameter int                SYNC_W    = 8,
    parameter logic [SYNC_W-1:0] SYNC_WORD = 8'hF0,
    parameter int                NUM_COEF  = 16,
    parameter int                ADDR_W    = 4
) (
    input  logic              iTck,
    input  logic              iTrst,
    input  logic              iShiftEn,
    input  logic              iTdi,
    input  logic              iUpdateDr,
    input  logic              iDesync,
    output logic              oTdo,
    output logic              oSynced,
    output logic              oWrEn,
    output logic [ADDR_W-1:0] oWrAddr,
    output logic [DATA_W-1:0] oWrData,
    output logic              oErr
);

    // The bit counter only has to tell "exactly DATA_W" apart from "more than
    // DATA_W", so it saturates one past DATA_W.
    localparam int                CNT_W     = $clog2(DATA_W + 2);
    localparam logic [CNT_W-1:0]  CNT_SAT   = CNT_W'(DATA_W + 1);
    localparam logic [CNT_W-1:0]  CNT_DATA  = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0]  CNT_SYNC  = CNT_W'(SYNC_W);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_COEF - 1);

    localparam logic [0:0] HUNT  = 1'b0;
    localparam logic [0:0] ARMED = 1'b1;

    logic [0:0]        state;
    logic [SYNC_W-1:0] sync_sr;
    logic [DATA_W-1:0] data_sr;
    logic [CNT_W-1:0]  bitcnt;
    logic [ADDR_W-1:0] next_addr;

    // Synced status is simply the decoded ARMED state.
    always_comb begin
        oSynced = (state == ARMED);
    end

    // Main sequencer. Priority on one edge is desync, then update, then shift,
    // so a bit shifted on the same edge as an update or desync is dropped.
    always_ff @(posedge iTck or negedge iTrst) begin
        if (!iTrst) begin
            state     <= HUNT;
            sync_sr   <= '0;
            data_sr   <= '0;
            bitcnt    <= '0;
            next_addr <= '0;
            oWrAddr   <= '0;
            oWrData   <= '0;
            oWrEn     <= 1'b0;
            oErr      <= 1'b0;
            oTdo      <= 1'b0;
        end else begin
            oWrEn <= 1'b0;
            oErr  <= 1'b0;
            if (iDesync) begin
                state  <= HUNT;
                bitcnt <= '0;
            end else if (iUpdateDr) begin
                bitcnt <= '0;
                if (state == HUNT) begin
                    if ((bitcnt >= CNT_SYNC) && (sync_sr == SYNC_WORD)) begin
                        state <= ARMED;
                    end
                end else if (bitcnt == CNT_DATA) begin
                    oWrEn     <= 1'b1;
                    oWrData   <= data_sr;
                    oWrAddr   <= next_addr;
                    next_addr <= (next_addr == ADDR_LAST) ? '0 : next_addr + ADDR_W'(1);
                end else begin
                    oErr <= 1'b1;
                end
            end else if (iShiftEn) begin
                if (bitcnt != CNT_SAT) begin
                    bitcnt <= bitcnt + CNT_W'(1);
                end
                if (state == HUNT) begin
                    sync_sr <= {iTdi, sync_sr[SYNC_W-1:1]};
                    oTdo    <= sync_sr[1];
                end else begin
                    data_sr <= {iTdi, data_sr[DATA_W-1:1]};
                    oTdo    <= data_sr[1];
                end
            end
        end
    end

endmodule

// File: tb/tb_cfg_chain_rx.sv
// Self-checking bench for cfg_chain_rx: directed scenarios followed by a
// randomized scan-level stream, all compared against a scan-queue model.
module tb_cfg_chain_rx;

    logic       iTck = 1'b0;
    logic       iTrst = 1'b0;
    logic       iShiftEn = 1'b0;
    logic       iTdi = 1'b0;
    logic       iUpdateDr = 1'b0;
    logic       iDesync = 1'b0;
    logic       oTdo;
    logic       oSynced;
    logic       oWrEn;
    logic [3:0] oWrAddr;
    logic [7:0] oWrData;
    logic       oErr;

    int vectors = 0;
    int miscompares = 0;

    cfg_chain_rx dut (
        .iTck      (iTck),
        .iTrst     (iTrst),
        .iShiftEn  (iShiftEn),
        .iTdi      (iTdi),
        .iUpdateDr (iUpdateDr),
        .iDesync   (iDesync),
        .oTdo      (oTdo),
        .oSynced   (oSynced),
        .oWrEn     (oWrEn),
        .oWrAddr   (oWrAddr),
        .oWrData   (oWrData),
        .oErr      (oErr)
    );

    // TCK generation.
    always #5 iTck = ~iTck;

    // Reference model: bits of the current scan, per-register shift history
    // since reset, synced flag and the next coefficient slot.
    bit         scan_q[$];
    bit         sync_h[$];
    bit         data_h[$];
    bit         m_synced;
    int         m_addr;
    logic       e_wr, e_err, e_tdo;
    logic [3:0] e_addr;
    logic [7:0] e_data;

    wire [15:0] dut_vec = {oWrEn, oErr, oSynced, oTdo, oWrAddr, oWrData};

    function automatic logic [15:0] exp_vec();
        return {e_wr, e_err, m_synced, e_tdo, e_addr, e_data};
    endfunction

    function automatic void model_reset();
        scan_q.delete();
        sync_h.delete();
        data_h.delete();
        m_synced = 1'b0;
        m_addr   = 0;
        e_wr     = 1'b0;
        e_err    = 1'b0;
        e_tdo    = 1'b0;
        e_addr   = '0;
        e_data   = '0;
    endfunction

    function automatic int last_value(int n);
        int v = 0;
        int sz = scan_q.size();
        for (int k = 0; k < n; k++) v += int'(scan_q[sz - n + k]) << k;
        return v;
    endfunction

    function automatic void model_edge(logic s, logic t, logic u, logic d);
        e_wr  = 1'b0;
        e_err = 1'b0;
        if (d) begin
            m_synced = 1'b0;
            scan_q.delete();
        end else if (u) begin
            if (!m_synced) begin
                if (scan_q.size() >= 8 && last_value(8) == 'hF0) m_synced = 1'b1;
            end else if (scan_q.size() == 8) begin
                e_wr   = 1'b1;
                e_data = 8'(last_value(8));
                e_addr = 4'(m_addr);
                m_addr = (m_addr + 1) % 16;
            end else begin
                e_err = 1'b1;
            end
            scan_q.delete();
        end else if (s) begin
            scan_q.push_back(t);
            if (m_synced) begin
                data_h.push_back(t);
                e_tdo = (data_h.size() >= 8) ? data_h[data_h.size() - 8] : 1'b0;
            end else begin
                sync_h.push_back(t);
                e_tdo = (sync_h.size() >= 8) ? sync_h[sync_h.size() - 8] : 1'b0;
            end
        end
    endfunction

    task automatic step(input logic s, input logic t, input logic u, input logic d);
        iShiftEn  = s;
        iTdi      = t;
        iUpdateDr = u;
        iDesync   = d;
        @(posedge iTck);
        model_edge(s, t, u, d);
        #1;
        iShiftEn  = 1'b0;
        iUpdateDr = 1'b0;
        iDesync   = 1'b0;
    endtask

    task automatic scan_bits(input logic [15:0] v, input int n);
        for (int k = 0; k < n; k++) step(1'b1, v[k], 1'b0, 1'b0);
    endtask

    task automatic update();
        step(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic apply_reset();
        iTrst = 1'b0;
        iShiftEn = 1'b0; iUpdateDr = 1'b0; iDesync = 1'b0; iTdi = 1'b0;
        model_reset();
        repeat (2) @(posedge iTck);
        #1;
        iTrst = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++;
        if (dut_vec !== 16'h0000) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs got %h exp %h", dut_vec, 16'h0000);
        end
        vectors++;
        if (dut_vec !== exp_vec()) begin
            miscompares++;
            $display("[TB] FAIL reset_model got %h exp %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_sync_data();
        scan_bits(16'h00F0, 8);
        update();
        vectors++;
        if (oSynced !== 1'b1 || dut_vec !== exp_vec()) begin
            miscompares++;
            $display("[TB] FAIL sync_arm got %h exp %h", dut_vec, exp_vec());
        end
        scan_bits(16'h0001, 8);
        update();
        vectors++;
        if (oWrEn !== 1'b1 || oWrAddr !== 4'd0 || oWrData !== 8'h01 || dut_vec !== exp_vec()) begin
            miscompares++;
            $display("[TB] FAIL first_write got %h exp %h", dut_vec, exp_vec());
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (oWrEn !== 1'b0 || dut_vec !== exp_vec()) begin
            miscompares++;
            $display("[TB] FAIL write_one_cycle got %h exp %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_repeated();
        for (int i = 1; i <= 255; i++) begin
            scan_bits(16'h00F0, 8);
            update();
            scan_bits(16'(i), 8);
            update();
            vectors++;
            if (oWrEn !== 1'b1 || oWrData !== 8'(i) || oWrAddr !== 4'((i - 1) % 16)
                || dut_vec !== exp_vec()) begin
                miscompares++;
                $display("[TB] FAIL repeat_write i=%0d got %h exp %h", i, dut_vec, exp_vec());
            end
            step(1'b0, 1'b0, 1'b0, 1'b1);
            vectors++;
            if (oSynced !== 1'b0 || dut_vec !== exp_vec()) begin
                miscompares++;
                $display("[TB] FAIL repeat_desync i=%0d got %h exp %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_bad_sync();
        logic [3:0] junk;
        scan_bits(16'h00F1, 8);
        update();
        vectors++;
        if (oSynced !== 1'b0 || dut_vec !== exp_vec()) begin
            miscompares++;
            $display("[TB] FAIL bad_sync got %h exp %h", dut_vec, exp_vec());
        end
        junk = 4'($urandom);
        scan_bits({4'h0, 8'hF0, junk}, 12);
        update();
        vectors++;
        if (oSynced !== 1'b1 || dut_vec !== exp_vec()) begin
            miscompares++;
            $display("[TB] FAIL junk_then_sync got %h exp %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_short_scan();
        scan_bits(16'h005A, 7);
        update();
        vectors++;
        if (oErr !== 1'b1 || oWrEn !== 1'b0 || dut_vec !== exp_vec()) begin
            miscompares++;
            $display("[TB] FAIL short_scan_err got %h exp %h", dut_vec, exp_vec());
        end
        scan_bits(16'h00A5, 8);
        update();
        vectors++;
        if (oWrEn !== 1'b1 || oWrData !== 8'hA5 || oErr !== 1'b0 || dut_vec !== exp_vec()) begin
            miscompares++;
            $display("[TB] FAIL after_err_write got %h exp %h", dut_vec, exp_vec());
        end
        scan_bits(16'h03FF, 9);
        update();
        vectors++;
        if (oErr !== 1'b1 || oWrEn !== 1'b0 || dut_vec !== exp_vec()) begin
            miscompares++;
            $display("[TB] FAIL long_scan_err got %h exp %h", dut_vec, exp_vec());
        end
        scan_bits(16'h0033, 7);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        vectors++;
        if (oErr !== 1'b1 || oWrEn !== 1'b0 || dut_vec !== exp_vec()) begin
            miscompares++;
            $display("[TB] FAIL update_drops_shift got %h exp %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_back_to_back();
        scan_bits(16'h00C3, 8);
        update();
        vectors++;
        if (oWrEn !== 1'b1 || oWrData !== 8'hC3 || dut_vec !== exp_vec()) begin
            miscompares++;
            $display("[TB] FAIL b2b_first got %h exp %h", dut_vec, exp_vec());
        end
        update();
        vectors++;
        if (oErr !== 1'b1 || oWrEn !== 1'b0 || dut_vec !== exp_vec()) begin
            miscompares++;
            $display("[TB] FAIL b2b_second got %h exp %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_desync_update();
        logic [3:0] addr_before;
        addr_before = oWrAddr;
        scan_bits(16'h0077, 8);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        vectors++;
        if (oWrEn !== 1'b0 || oErr !== 1'b0 || oSynced !== 1'b0 || oWrAddr !== addr_before
            || dut_vec !== exp_vec()) begin
            miscompares++;
            $display("[TB] FAIL desync_with_update got %h exp %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_reset_midscan();
        scan_bits(16'h00F0, 8);
        update();
        scan_bits(16'h003C, 8);
        update();
        iTrst = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (dut_vec !== 16'h0000) begin
            miscompares++;
            $display("[TB] FAIL reset_kills_write got %h exp %h", dut_vec, 16'h0000);
        end
        @(posedge iTck);
        #1;
        iTrst = 1'b1;
        scan_bits(16'h00F0, 8);
        update();
        scan_bits(16'h000F, 4);
        apply_reset();
        vectors++;
        if (oSynced !== 1'b0 || oWrAddr !== 4'd0 || dut_vec !== exp_vec()) begin
            miscompares++;
            $display("[TB] FAIL reset_midscan got %h exp %h", dut_vec, exp_vec());
        end
        scan_bits(16'h00F0, 8);
        update();
        scan_bits(16'h005A, 8);
        update();
        vectors++;
        if (oWrEn !== 1'b1 || oWrData !== 8'h5A || oWrAddr !== 4'd0 || dut_vec !== exp_vec()) begin
            miscompares++;
            $display("[TB] FAIL write_after_reset got %h exp %h", dut_vec, exp_vec());
        end
    endtask

    typedef struct packed {
        logic s;
        logic t;
        logic u;
        logic d;
    } stim_t;

    task automatic test_random();
        stim_t sq[$];
        stim_t c;
        int    n;
        logic [15:0] v;
        repeat (400) begin
            case ($urandom_range(0, 9))
                0, 1, 2: begin
                    n = $urandom_range(0, 4);
                    v = 16'($urandom);
                    v = (v & ((16'd1 << n) - 16'd1)) | (16'h00F0 << n);
                    if ($urandom_range(0, 3) == 0) v[$urandom_range(0, n + 7)] ^= 1'b1;
                    for (int k = 0; k < n + 8; k++) sq.push_back('{1'b1, v[k], 1'b0, 1'b0});
                    sq.push_back('{1'b0, 1'b0, 1'b1, 1'b0});
                end
                3, 4, 5, 6: begin
                    n = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 10) : 8;
                    v = 16'($urandom);
                    for (int k = 0; k < n; k++) sq.push_back('{1'b1, v[k], 1'b0, 1'b0});
                    sq.push_back('{1'($urandom), 1'($urandom), 1'b1, 1'b0});
                end
                7: sq.push_back('{1'($urandom), 1'($urandom), 1'($urandom), 1'b1});
                8: repeat ($urandom_range(1, 3)) sq.push_back('{1'b0, 1'b0, 1'b0, 1'b0});
                default: repeat (2) sq.push_back('{1'b0, 1'b0, 1'b1, 1'b0});
            endcase
        end
        while (sq.size() > 0) begin
            c = sq.pop_front();
            step(c.s, c.t, c.u, c.d);
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("[TB] FAIL random_cycle s%0b t%0b u%0b d%0b got %h exp %h",
                         c.s, c.t, c.u, c.d, dut_vec, exp_vec());
            end
        end
    endtask

    // Scenario sequence, then the summary line.
    initial begin
        model_reset();
        test_reset();
        test_sync_data();
        apply_reset();
        test_repeated();
        apply_reset();
        test_bad_sync();
        test_short_scan();
        test_back_to_back();
        test_desync_update();
        test_reset_midscan();
        apply_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
